host_bus_fabric: RTL and testbench

Parametrised host-bus address decoder and transfer sequencer for the 2A03 core bus. It replaces fixed RAM/PPU/cartridge decoding with a table of `P_channels` address windows. Each window has its own wait-state count, and the block holds the core's `I_ready` low while a slow slave is accessed. It issues a single-cycle commit strobe per transfer and returns the last bus value (open bus) on unmapped reads. It sits between `core` and the RAM, PPU and cartridge slaves in the top-level console.

---
 rtl/host_bus_fabric.sv | 190 +++++++++++++++++++
 tb/tb_host_bus_fabric.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_fabric.sv
// host_bus_fabric: address decoder and transfer sequencer for the 2A03 core bus.
//
// A table of P_channels address windows replaces fixed decoding. Each window
// has its own wait-state count. The block holds the core's ready low while a
// slow slave is accessed, fires a one-cycle commit strobe per transfer, and
// returns the last bus value (open bus) on unmapped reads.
//
// Ports:
//   I_clock, I_reset     clock; asynchronous active-low reset
//   I_addr, I_rden,      core address and read/write strobes (rden & wren
//   I_wren, I_wr_data    together counts as a write), core write data
//   I_rd_data            slave read data, channel i in [8i+7:8i]
//   O_rd_data            read data to the core (live slave data or open bus)
//   O_ready              low stalls the core
//   O_select             one-hot live window decode, zero on a miss
//   O_strobe             one-cycle commit pulse to the serviced slave
//   O_miss               one-cycle pulse when an access hits no window

// Single address window match; mask bit 0 = don't care (mirroring).
module host_bus_win #(
  parameter logic [15:0] P_base_w = 16'h0000,
  parameter logic [15:0] P_mask_w = 16'h0000
) (
  input  logic [15:0] I_addr,
  output logic        O_hit
);
  assign O_hit = ((I_addr ^ P_base_w) & P_mask_w) == 16'h0000;
endmodule

module host_bus_fabric #(
  parameter int                              P_channels   = 3,
  parameter int                              P_wait_bits  = 3,
  parameter logic [P_channels*16-1:0]        P_base       = {16'h0000, 16'h2000, 16'h0000},
  parameter logic [P_channels*16-1:0]        P_mask       = {16'h0000, 16'hE000, 16'hE000},
  parameter logic [P_channels*P_wait_bits-1:0] P_wait     = {3'd2, 3'd1, 3'd0},
  parameter logic [7:0]                      P_open_reset = 8'hFF
) (
  input  logic                      I_clock,
  input  logic                      I_reset,
  input  logic [15:0]               I_addr,
  input  logic                      I_rden,
  input  logic                      I_wren,
  input  logic [7:0]                I_wr_data,
  input  logic [P_channels*8-1:0]   I_rd_data,
  output logic [7:0]                O_rd_data,
  output logic                      O_ready,
  output logic [P_channels-1:0]     O_select,
  output logic [P_channels-1:0]     O_strobe,
  output logic                      O_miss
);

  localparam int CW = (P_channels > 1) ? $clog2(P_channels) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Context of the transfer in flight: address for the DONE hold compare,
  // channel so a stalled transfer ignores later address changes.
  typedef struct packed {
    logic [15:0]   addr;
    logic [CW-1:0] ch;
  } xfer_t;

  state_t                               state, state_nxt;
  logic [P_wait_bits-1:0]               cnt, cnt_nxt;
  xfer_t                                xfer, xfer_nxt;
  logic [7:0]                           open_bus, open_nxt;

  logic [P_channels-1:0]                hit_vec;
  logic [P_channels-1:0][7:0]           slv_data;
  logic [P_channels-1:0][P_wait_bits-1:0] ch_wait;
  logic                                 live_hit;
  logic [CW-1:0]                        live_ch;
  logic                                 access, is_wr, is_rd, eval_new;
  logic                                 rd_hit;
  logic [CW-1:0]                        rd_ch;

  assign slv_data = I_rd_data;
  assign ch_wait  = P_wait;
  assign access   = I_rden | I_wren;
  assign is_wr    = I_wren;
  assign is_rd    = I_rden & ~I_wren;

  for (genvar g = 0; g < P_channels; g++) begin : g_win
    host_bus_win #(
      .P_base_w(P_base[16*g +: 16]),
      .P_mask_w(P_mask[16*g +: 16])
    ) u_win (
      .I_addr(I_addr),
      .O_hit (hit_vec[g])
    );
  end

  function automatic logic [P_channels-1:0] onehot(input logic [CW-1:0] ch);
    onehot = '0;
    for (int i = 0; i < P_channels; i++)
      if (ch == CW'(i)) onehot[i] = 1'b1;
  endfunction

  // Lowest index wins: scan downward so the last assignment is the lowest hit.
  always_comb begin
    live_hit = 1'b0;
    live_ch  = '0;
    for (int i = P_channels - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        live_hit = 1'b1;
        live_ch  = CW'(i);
      end
    end
  end

  assign O_select = live_hit ? onehot(live_ch) : '0;

  // A stalled transfer reads from its latched channel; otherwise live decode.
  assign rd_ch     = (state == S_WAIT) ? xfer.ch : live_ch;
  assign rd_hit    = (state == S_WAIT) ? 1'b1    : live_hit;
  assign O_rd_data = (is_rd && rd_hit) ? slv_data[rd_ch] : open_bus;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xfer_nxt  = xfer;
    open_nxt  = open_bus;
    O_ready   = 1'b1;
    O_strobe  = '0;
    O_miss    = 1'b0;
    eval_new  = 1'b0;

    case (state)
      S_IDLE: eval_new = access;
      S_WAIT: begin
        if (!access) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          O_strobe  = onehot(xfer.ch);
          open_nxt  = is_wr ? I_wr_data : slv_data[xfer.ch];
          state_nxt = S_DONE;
        end else begin
          O_ready = 1'b0;
          cnt_nxt = cnt - P_wait_bits'(1);
        end
      end
      S_DONE: begin
        if (!access)                    state_nxt = S_IDLE;
        else if (I_addr != xfer.addr)   eval_new  = 1'b1;  // back-to-back
      end
      default: state_nxt = S_IDLE;
    endcase

    // New transfer evaluation, shared by IDLE and a changed address in DONE.
    if (eval_new) begin
      xfer_nxt.addr = I_addr;
      xfer_nxt.ch   = live_ch;
      if (!live_hit) begin
        O_miss    = 1'b1;
        if (is_wr) open_nxt = I_wr_data;
        state_nxt = S_DONE;
      end else if (ch_wait[live_ch] == '0) begin
        O_strobe  = onehot(live_ch);
        open_nxt  = is_wr ? I_wr_data : slv_data[live_ch];
        state_nxt = S_DONE;
      end else begin
        O_ready   = 1'b0;
        cnt_nxt   = ch_wait[live_ch] - P_wait_bits'(1);
        state_nxt = S_WAIT;
      end
    end

    // Outputs take their idle values for as long as reset is held.
    if (!I_reset) begin
      O_ready  = 1'b1;
      O_strobe = '0;
      O_miss   = 1'b0;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      xfer     <= '0;
      open_bus <= P_open_reset;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      xfer     <= xfer_nxt;
      open_bus <= open_nxt;
    end
  end

endmodule

// File: tb/tb_host_bus_fabric.sv
module tb_host_bus_fabric;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rden, wren;
  logic [7:0]  wdata;
  logic [23:0] rdd;

  logic [7:0]  o_rd, m_rd;
  logic        o_ready, m_ready, o_miss, m_miss;
  logic [2:0]  o_sel, m_sel, o_stb, m_stb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  host_bus_fabric dut (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr), .I_rden(rden), .I_wren(wren),
    .I_wr_data(wdata), .I_rd_data(rdd), .O_rd_data(o_rd), .O_ready(o_ready),
    .O_select(o_sel), .O_strobe(o_stb), .O_miss(o_miss)
  );

  // Same map but ch2 no longer a catch-all, so unmapped addresses exist.
  host_bus_fabric #(.P_mask({16'hFFFF, 16'hE000, 16'hE000})) dut_m (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr), .I_rden(rden), .I_wren(wren),
    .I_wr_data(wdata), .I_rd_data(rdd), .O_rd_data(m_rd), .O_ready(m_ready),
    .O_select(m_sel), .O_strobe(m_stb), .O_miss(m_miss)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the default map ----------------
  logic [15:0] mbase [3] = '{16'h0000, 16'h2000, 16'h0000};
  logic [15:0] mmask [3] = '{16'hE000, 16'hE000, 16'h0000};
  int          mwait [3] = '{0, 1, 2};

  bit          busy = 0, done = 0;
  int          age = 0, ep_ch = -1;
  logic [15:0] ep_addr = '0;
  logic [7:0]  latch = 8'hFF;

  function automatic int decode(input logic [15:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & mmask[i]) == (mbase[i] & mmask[i])) return i;
    return -1;
  endfunction

  // An access episode starts when an access appears after idle, or when the
  // address changes after a finished transfer. It finishes once it has been
  // seen for W cycles (age counted from 0).
  task automatic model_cycle();
    bit acc, wr, rdop, compl;
    int lch;
    logic [2:0] esel, estb;
    logic eready, emiss;
    logic [7:0] erd;
    if (!rst_n) begin
      busy = 0; done = 0; age = 0; latch = 8'hFF;
      chk("m_rst_ready", o_ready, 1);
      chk("m_rst_strobe", o_stb, 0);
      chk("m_rst_miss", o_miss, 0);
    end else begin
      acc  = rden | wren;
      wr   = wren;
      rdop = rden & !wren;
      lch  = decode(addr);
      esel = (lch < 0) ? 3'b000 : 3'(1 << lch);
      if (acc && (!busy || (done && addr != ep_addr))) begin
        busy = 1; done = 0; age = 0; ep_ch = lch; ep_addr = addr;
      end
      eready = 1; estb = 0; emiss = 0; compl = 0;
      if (acc && !done) begin
        if (ep_ch < 0) begin
          emiss = 1; compl = 1;
        end else if (age == mwait[ep_ch]) begin
          estb = 3'(1 << ep_ch); compl = 1;
        end else begin
          eready = 0;
        end
      end
      erd = (acc && rdop && ep_ch >= 0) ? rdd[ep_ch*8 +: 8] : latch;
      chk("m_select", o_sel, esel);
      chk("m_ready", o_ready, eready);
      chk("m_strobe", o_stb, estb);
      chk("m_miss", o_miss, emiss);
      chk("m_rd_data", o_rd, erd);
      if (!acc) busy = 0;
      else if (compl) begin
        done = 1;
        if (wr) latch = wdata;
        else if (ep_ch >= 0) latch = rdd[ep_ch*8 +: 8];
      end else if (!done) age++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_cycle();
  end

  // ---------------- directed vectors ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    int nstb;
    rst_n = 1'b1; addr = '0; rden = 0; wren = 0; wdata = '0; rdd = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_ready", o_ready, 1);
    chk("reset_strobe", o_stb, 0);
    chk("reset_open_bus", o_rd, 8'hFF);
    nxt(); rst_n = 1'b1;

    // RAM read, zero wait
    nxt(); addr = 16'h0005; rden = 1; rdd = 24'h77_66_3C;
    @(negedge clk);
    chk("ram_ready", o_ready, 1);
    chk("ram_strobe", o_stb, 3'b001);
    chk("ram_rd_data", o_rd, 8'h3C);
    nxt(); rden = 0;
    @(negedge clk);
    chk("ram_latch", o_rd, 8'h3C);
    chk("ram_no_restrobe", o_stb, 0);

    // mirrored PPU write, one wait
    nxt(); addr = 16'h3FF8; wren = 1; wdata = 8'hA5;
    @(negedge clk);
    chk("ppu_select", o_sel, 3'b010);
    chk("ppu_ready_c0", o_ready, 0);
    chk("ppu_strobe_c0", o_stb, 0);
    nxt();
    @(negedge clk);
    chk("ppu_ready_c1", o_ready, 1);
    chk("ppu_strobe_c1", o_stb, 3'b010);
    nxt(); wren = 0;
    @(negedge clk);
    chk("ppu_latch", o_rd, 8'hA5);

    // cartridge read, two waits, then held 3 more cycles
    nxt(); addr = 16'h8000; rden = 1; rdd = 24'hEA_00_00;
    nstb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 2) chk("cart_ready_low", o_ready, 0);
      if (c == 2) begin
        chk("cart_strobe", o_stb, 3'b100);
        chk("cart_rd_data", o_rd, 8'hEA);
      end
      if (o_stb != 0) nstb++;
      nxt();
    end
    chk("cart_strobe_count", nstb, 1);
    rden = 0;
    @(negedge clk);
    chk("cart_latch", o_rd, 8'hEA);

    // miss on the restricted map: write $34 to RAM, then read unmapped $4020
    nxt(); addr = 16'h1234; wren = 1; wdata = 8'h34;
    @(negedge clk);
    chk("miss_wr_no_miss", m_miss, 0);
    chk("miss_wr_strobe", m_stb, 3'b001);
    nxt(); wren = 0; rden = 1; addr = 16'h4020; rdd = 24'h5A_5A_5A;
    @(negedge clk);
    chk("miss_pulse", m_miss, 1);
    chk("miss_rd_data", m_rd, 8'h34);
    chk("miss_ready", m_ready, 1);
    chk("miss_select", m_sel, 3'b000);
    chk("miss_strobe", m_stb, 3'b000);
    nxt();
    @(negedge clk);
    chk("miss_single_pulse", m_miss, 0);
    chk("miss_hold_data", m_rd, 8'h34);
    nxt(); nxt(); rden = 0;

    // abort mid-WAIT, then restart from a fresh count
    nxt(); addr = 16'h8000; rden = 1; rdd = 24'hC3_22_11;
    @(negedge clk); chk("abort_ready_c0", o_ready, 0);
    nxt();
    @(negedge clk); chk("abort_ready_c1", o_ready, 0);
    nxt(); rden = 0;
    @(negedge clk); chk("abort_no_strobe", o_stb, 0);
    nxt(); rden = 1;
    @(negedge clk);
    chk("abort_restart_ready", o_ready, 0);
    chk("abort_restart_strobe", o_stb, 0);
    nxt(); rden = 0;

    // back-to-back with held read and changing address
    nxt(); addr = 16'h0000; rden = 1;
    @(negedge clk);
    chk("b2b_strobe_0", o_stb, 3'b001);
    chk("b2b_rd_data", o_rd, 8'h11);
    nxt(); addr = 16'h0001;
    @(negedge clk); chk("b2b_strobe_1", o_stb, 3'b001);
    nxt();
    @(negedge clk); chk("b2b_hold_no_strobe", o_stb, 0);
    nxt(); rden = 0;

    // reset during a cartridge wait
    nxt(); addr = 16'h8000; rden = 1;
    nxt();
    chk("rst_wait_ready", o_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", o_ready, 1);
    chk("rst_async_strobe", o_stb, 0);
    nxt(); rden = 0;
    @(negedge clk); chk("rst_open_bus", o_rd, 8'hFF);
    nxt(); rst_n = 1'b1; addr = 16'h0005; rden = 1; rdd = 24'h00_00_3C;
    @(negedge clk);
    chk("post_rst_strobe", o_stb, 3'b001);
    chk("post_rst_ready", o_ready, 1);
    nxt(); rden = 0;
    @(negedge clk); chk("post_rst_latch", o_rd, 8'h3C);

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
